fir_mc_mac_engine: RTL and testbench

Parametrised multi-channel FIR engine: one time-multiplexed multiply-accumulate unit serves NUM_CH independent channels. Each channel has its own sample delay line; all channels share one coefficient set. It is the successor datapath behind the FIR register block. Coefficient and tap-count writes arrive from the control unit. Samples and results move on valid/ready streams, with saturating scaled output and sticky error flags.

---
 rtl/fir_mc_mac_engine.sv | 207 ++++++++++++++++++++
 tb/tb_fir_mc_mac_engine.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mc_mac_engine.sv
// Multi-channel FIR engine. One time-multiplexed multiply-accumulate unit
// serves NUM_CH channels. Each channel has its own circular sample delay
// line, and all channels share one coefficient set. Each result is scaled,
// saturated and presented on a valid/ready stream. Configuration errors,
// channel errors and saturation are reported on sticky flags.
module fir_mc_mac_engine #(
  parameter int  DATA_W    = 16,
  parameter int  COEF_W    = 16,
  parameter int  MAX_TAPS  = 32,
  parameter int  NUM_CH    = 2,
  parameter int  OUT_W     = 32,
  parameter int  OUT_SHIFT = 0,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     tap_count_we,
  input  logic [31:0]              tap_count,
  input  logic                     coeff_start,
  input  logic                     coeff_valid,
  input  logic signed [COEF_W-1:0] coeff_data,
  output logic                     coeff_ready,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_ch,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic signed [OUT_W-1:0]  out_data,
  input  logic                     err_clr,
  output logic                     cfg_err,
  output logic                     ch_err,
  output logic                     sat_flag
);

  localparam int AW     = $clog2(MAX_TAPS);
  localparam int TW     = AW + 1;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + AW;
  localparam int EXT_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;

  localparam logic [TW-1:0] MAX_IDX = TW'(MAX_TAPS);
  localparam logic signed [EXT_W-1:0] OUT_MAX =
    {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] OUT_MIN =
    {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_e;

  state_e                    state_q, state_d;
  logic                      rdy_en_q;
  logic [TW-1:0]             tap_q, tap_d;
  logic [TW-1:0]             widx_q, widx_d, widx_eff;
  logic [AW-1:0]             k_q, k_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d, acc_sum;
  logic signed [OUT_W-1:0]   out_data_q, out_data_d;
  logic                      cfg_err_q, ch_err_q, sat_q;
  logic                      cfg_ev, ch_ev, sat_ev;
  logic                      coeff_we, x_we, wptr_inc;
  logic [AW-1:0]             coeff_waddr;

  logic signed [COEF_W-1:0]  coeff_q [MAX_TAPS];
  logic signed [DATA_W-1:0]  x_q     [NUM_CH][MAX_TAPS];
  logic [AW-1:0]             wptr_q  [NUM_CH];

  logic [AW-1:0]             rd_idx;
  logic signed [PROD_W-1:0]  prod;
  logic signed [EXT_W-1:0]   acc_ext, s_ext;
  logic                      ch_ok, mac_last, sat_hi, sat_lo;
  logic signed [OUT_W-1:0]   sat_val;

  // Datapath: product of tap k, running sum, then scaling and saturation of that sum.
  always_comb begin
    rd_idx   = wptr_q[ch_q] - k_q;  // wraps modulo MAX_TAPS (power of two)
    prod     = coeff_q[k_q] * x_q[ch_q][rd_idx];
    acc_sum  = acc_q + ACC_W'(prod);
    acc_ext  = EXT_W'(acc_sum);
    s_ext    = acc_ext >>> OUT_SHIFT;
    sat_hi   = (s_ext > OUT_MAX);
    sat_lo   = (s_ext < OUT_MIN);
    sat_val  = sat_hi ? OUT_MAX[OUT_W-1:0] :
               sat_lo ? OUT_MIN[OUT_W-1:0] : s_ext[OUT_W-1:0];
    mac_last = ({1'b0, k_q} == (tap_q - TW'(1)));
    ch_ok    = (32'(in_ch) < NUM_CH);
  end

  // Control FSM: next state, configuration writes, handshakes and error events.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned, which would infer a latch.
    state_d     = state_q;
    tap_d       = tap_q;
    widx_d      = widx_q;
    widx_eff    = coeff_start ? '0 : widx_q;
    k_d         = k_q;
    ch_d        = ch_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    cfg_ev      = 1'b0;
    ch_ev       = 1'b0;
    sat_ev      = 1'b0;
    coeff_we    = 1'b0;
    coeff_waddr = '0;
    x_we        = 1'b0;
    wptr_inc    = 1'b0;
    in_ready    = rdy_en_q && (state_q == S_IDLE);
    coeff_ready = rdy_en_q && (state_q == S_IDLE);
    out_valid   = (state_q == S_OUT);

    unique case (state_q)
      S_IDLE: begin
        if (rdy_en_q) begin
          if (tap_count_we) begin
            if (tap_count == 0 || tap_count > MAX_TAPS) cfg_ev = 1'b1;
            else                                        tap_d  = tap_count[TW-1:0];
          end
          if (coeff_start) widx_d = '0;
          if (coeff_valid) begin
            if (widx_eff == MAX_IDX) begin
              cfg_ev = 1'b1;
            end else begin
              coeff_we    = 1'b1;
              coeff_waddr = widx_eff[AW-1:0];
              widx_d      = widx_eff + TW'(1);
            end
          end
          if (in_valid) begin
            if (ch_ok) begin
              x_we    = 1'b1;
              ch_d    = in_ch;
              acc_d   = '0;
              k_d     = '0;
              state_d = S_MAC;
            end else begin
              ch_ev = 1'b1;
            end
          end
        end
      end
      S_MAC: begin
        acc_d = acc_sum;
        if (mac_last) begin
          out_data_d = sat_val;
          sat_ev     = sat_hi || sat_lo;
          wptr_inc   = 1'b1;
          state_d    = S_OUT;
        end else begin
          k_d = k_q + AW'(1);
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, storage and sticky flags, all with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      // NOTE: coefficient and delay-line storage is explicitly reset because
      // a restart must behave as all-zero coefficients and empty history.
      state_q    <= S_IDLE;
      rdy_en_q   <= 1'b0;
      tap_q      <= TW'(1);
      widx_q     <= '0;
      k_q        <= '0;
      ch_q       <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      cfg_err_q  <= 1'b0;
      ch_err_q   <= 1'b0;
      sat_q      <= 1'b0;
      for (int t = 0; t < MAX_TAPS; t++) coeff_q[t] <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        wptr_q[c] <= '0;
        for (int t = 0; t < MAX_TAPS; t++) x_q[c][t] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q    <= state_d;
      rdy_en_q   <= 1'b1;
      tap_q      <= tap_d;
      widx_q     <= widx_d;
      k_q        <= k_d;
      ch_q       <= ch_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      cfg_err_q  <= (cfg_err_q && !err_clr) || cfg_ev;
      ch_err_q   <= (ch_err_q  && !err_clr) || ch_ev;
      sat_q      <= (sat_q     && !err_clr) || sat_ev;
      if (coeff_we) coeff_q[coeff_waddr] <= coeff_data;
      if (x_we)     x_q[in_ch][wptr_q[in_ch]] <= in_data;
      if (wptr_inc) wptr_q[ch_q] <= wptr_q[ch_q] + AW'(1);
    end
  end

  assign out_ch   = ch_q;
  assign out_data = out_data_q;
  assign cfg_err  = cfg_err_q;
  assign ch_err   = ch_err_q;
  assign sat_flag = sat_q;

endmodule

// File: tb/tb_fir_mc_mac_engine.sv
// Directed bench for fir_mc_mac_engine. The DUT uses three channels, so that
// in_ch == NUM_CH can be driven, and a 16-bit output, so that saturation can
// be reached. Inputs change on the falling edge and outputs are sampled there.
module tb_fir_mc_mac_engine;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               tap_count_we = 1'b0;
  logic [31:0]        tap_count = '0;
  logic               coeff_start = 1'b0;
  logic               coeff_valid = 1'b0;
  logic signed [15:0] coeff_data = '0;
  logic               coeff_ready;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [1:0]         in_ch = '0;
  logic signed [15:0] in_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [1:0]         out_ch;
  logic signed [15:0] out_data;
  logic               err_clr = 1'b0;
  logic               cfg_err, ch_err, sat_flag;

  int n_checks = 0;
  int n_pass   = 0;

  fir_mc_mac_engine #(
    .DATA_W(16), .COEF_W(16), .MAX_TAPS(32), .NUM_CH(3), .OUT_W(16), .OUT_SHIFT(0)
  ) dut (
    .clk(clk), .rstn(rstn),
    .tap_count_we(tap_count_we), .tap_count(tap_count),
    .coeff_start(coeff_start), .coeff_valid(coeff_valid), .coeff_data(coeff_data),
    .coeff_ready(coeff_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data),
    .err_clr(err_clr), .cfg_err(cfg_err), .ch_err(ch_err), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // All helpers are entered and left just after a falling edge.
  task automatic set_taps(input logic [31:0] v);
    tap_count_we = 1'b1; tap_count = v;
    @(negedge clk);
    tap_count_we = 1'b0;
  endtask

  task automatic coeff_write(input logic signed [15:0] v, input logic start);
    coeff_valid = 1'b1; coeff_start = start; coeff_data = v;
    @(negedge clk);
    coeff_valid = 1'b0; coeff_start = 1'b0;
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  // Send one sample, then check the result value, its channel and its latency.
  // The result is held with out_ready low for `hold` cycles before it is taken.
  task automatic run_sample(input string tag, input logic [1:0] ch,
                            input logic signed [15:0] din, input int taps,
                            input logic signed [15:0] exp, input int hold);
    int n;
    logic signed [15:0] held;
    in_valid = 1'b1; in_ch = ch; in_data = din;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check({tag, " in_ready before accept"}, in_ready, 1);
    @(negedge clk);                       // accept edge has passed
    in_valid = 1'b0;
    check({tag, " in_ready busy"}, in_ready, 0);
    // n counts edges after the accept edge. out_valid must be seen after edge
    // `taps`, so the first edge that samples it is accept + taps + 1.
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    check({tag, " latency"}, n, taps);
    check({tag, " out_data"}, out_data, exp);
    check({tag, " out_ch"}, out_ch, ch);
    held = out_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " held out_valid"}, out_valid, 1);
      check({tag, " held in_ready"}, in_ready, 0);
      check({tag, " held out_data"}, out_data, held);
    end
    out_ready = 1'b1;
    @(negedge clk);                       // handshake edge has passed
    out_ready = 1'b0;
    check({tag, " out_valid dropped"}, out_valid, 0);
    check({tag, " in_ready after handshake"}, in_ready, 1);
  endtask

  initial begin
    bit seen;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst in_ready", in_ready, 0);
    check("rst coeff_ready", coeff_ready, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_ch", out_ch, 0);
    check("rst out_data", out_data, 0);
    check("rst cfg_err", cfg_err, 0);
    check("rst ch_err", ch_err, 0);
    check("rst sat_flag", sat_flag, 0);
    rstn = 1'b1;
    @(negedge clk);
    check("post-rst in_ready", in_ready, 1);
    check("post-rst coeff_ready", coeff_ready, 1);

    // Impulse response on ch0: taps 3, coefficients 1,2,3.
    set_taps(3);
    coeff_write(16'sd1, 1'b1);
    coeff_write(16'sd2, 1'b0);
    coeff_write(16'sd3, 1'b0);
    run_sample("imp0", 2'd0, 16'sd1, 3, 16'sd1, 0);
    run_sample("imp1", 2'd0, 16'sd0, 3, 16'sd2, 0);
    run_sample("imp2", 2'd0, 16'sd0, 3, 16'sd3, 0);
    run_sample("imp3", 2'd0, 16'sd0, 3, 16'sd0, 0);

    // Channel isolation with interleaved samples.
    run_sample("iso ch0 a", 2'd0, 16'sd1,  3, 16'sd1,  0);
    run_sample("iso ch1 a", 2'd1, 16'sd10, 3, 16'sd10, 0);
    run_sample("iso ch0 b", 2'd0, 16'sd0,  3, 16'sd2,  0);
    run_sample("iso ch1 b", 2'd1, 16'sd0,  3, 16'sd20, 0);

    // Out-of-range channel: the sample is dropped and flagged, with no result.
    in_valid = 1'b1; in_ch = 2'd3; in_data = 16'sd99;
    @(negedge clk);
    in_valid = 1'b0;
    check("bad ch ch_err", ch_err, 1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("bad ch no output", seen, 0);
    check("bad ch in_ready", in_ready, 1);
    clear_errors();
    check("bad ch ch_err cleared", ch_err, 0);

    // Illegal tap counts are rejected; 3 taps stay in force.
    set_taps(0);
    check("taps 0 cfg_err", cfg_err, 1);
    clear_errors();
    check("taps cfg_err cleared", cfg_err, 0);
    set_taps(33);
    check("taps 33 cfg_err", cfg_err, 1);
    clear_errors();
    run_sample("taps kept ch2", 2'd2, 16'sd5, 3, 16'sd5, 0);

    // Saturation. The start and first write share a cycle, so index 0 is written.
    set_taps(2);
    coeff_write(16'sd32767, 1'b1);
    coeff_write(16'sd32767, 1'b0);
    run_sample("sat first",  2'd0, 16'sd32767, 2, 16'sd32767, 0);
    check("sat first flag", sat_flag, 1);
    run_sample("sat second", 2'd0, 16'sd32767, 2, 16'sd32767, 0);
    check("sat second flag", sat_flag, 1);
    clear_errors();
    check("sat flag cleared", sat_flag, 0);
    run_sample("sat neg", 2'd1, -16'sd32768, 2, -16'sd32768, 0);
    check("sat neg flag", sat_flag, 1);
    clear_errors();

    // Coefficient overflow: the 33rd write is dropped, not wrapped to index 0.
    set_taps(1);
    coeff_start = 1'b1;
    @(negedge clk);
    coeff_start = 1'b0;
    coeff_write(16'sd1, 1'b0);
    for (int i = 1; i < 32; i++) coeff_write(16'sd0, 1'b0);
    check("32 writes no cfg_err", cfg_err, 0);
    coeff_write(16'sd7, 1'b0);
    check("33rd write cfg_err", cfg_err, 1);
    // With backpressure: the result is held for 5 cycles before out_ready.
    run_sample("drop+bp ch2", 2'd2, 16'sd1, 1, 16'sd1, 5);
    // Back-to-back: accepted on the edge right after the handshake.
    run_sample("b2b ch2", 2'd2, 16'sd4, 1, 16'sd4, 0);
    clear_errors();

    // Reset while in MAC: the result is discarded and storage is reinitialised.
    set_taps(8);
    in_valid = 1'b1; in_ch = 2'd0; in_data = 16'sd1;
    check("rst-mac in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;                          // sampled on MAC cycle 4
    repeat (2) @(negedge clk);
    check("rst-mac out_valid in reset", out_valid, 0);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("rst-mac no out_valid", seen, 0);
    run_sample("post-rst impulse", 2'd0, 16'sd1, 1, 16'sd0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
